// File: rtl/uart_loopback.sv
// UART echo block: an 8N1 receiver feeds a one-byte holding buffer that drives an 8N1 transmitter.
// Every byte that arrives on rx is sent back on tx unchanged. Receive and transmit run at the same time.
module uart_loopback #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rxState_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_e;

    logic             rxMeta_q;
    logic             rxSync_q;
    logic             rxPrev_q;
    logic [2:0]       rxFill_q;
    logic             rxFall;

    rxState_e         rxState_q, rxState_d;
    logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]       rxBitIdx_q, rxBitIdx_d;
    logic [7:0]       rxShift_q, rxShift_d;
    logic             rxValid;

    logic             bufFull_q;
    logic [7:0]       bufData_q;
    logic             txTake;

    txState_e         txState_q, txState_d;
    logic [CNT_W-1:0] txCnt_q, txCnt_d;
    logic [2:0]       txBitIdx_q, txBitIdx_d;
    logic [7:0]       txShift_q, txShift_d;
    logic             txOut_q, txOut_d;

    // The synchroniser flops reset to the idle level.
    // rxFill_q marks when rxPrev_q holds a real sample of the line.
    // Without it, holding rx low through reset release would look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
            rxFill_q <= 3'b000;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            rxFill_q <= {rxFill_q[1:0], 1'b1};
        end
    end

    assign rxFall = rxFill_q[2] & rxPrev_q & ~rxSync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState_q  <= RX_IDLE;
            rxCnt_q    <= '0;
            rxBitIdx_q <= '0;
            rxShift_q  <= '0;
        end else begin
            rxState_q  <= rxState_d;
            rxCnt_q    <= rxCnt_d;
            rxBitIdx_q <= rxBitIdx_d;
            rxShift_q  <= rxShift_d;
        end
    end

    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q;
        rxBitIdx_d = rxBitIdx_q;
        rxShift_d  = rxShift_q;
        rxValid    = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (rxFall) begin
                    rxState_d = RX_START;
                    rxCnt_d   = '0;
                end
            end
            RX_START: begin
                if (rxCnt_q == HALF_LAST) begin
                    rxCnt_d    = '0;
                    rxBitIdx_d = '0;
                    rxState_d  = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == BIT_LAST) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    if (rxBitIdx_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end else begin
                        rxBitIdx_d = rxBitIdx_q + 3'd1;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == BIT_LAST) begin
                    rxCnt_d = '0;
                    if (rxSync_q) begin
                        rxValid   = 1'b1;
                        rxState_d = RX_IDLE;
                    end else begin
                        rxState_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rxSync_q) begin
                    rxState_d = RX_IDLE;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // If a new byte arrives in the same clock that TX takes the old one, the new byte stays buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufFull_q <= 1'b0;
            bufData_q <= '0;
        end else if (rxValid) begin
            bufFull_q <= 1'b1;
            bufData_q <= rxShift_q;
        end else if (txTake) begin
            bufFull_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState_q  <= TX_IDLE;
            txCnt_q    <= '0;
            txBitIdx_q <= '0;
            txShift_q  <= '0;
            txOut_q    <= 1'b1;
        end else begin
            txState_q  <= txState_d;
            txCnt_q    <= txCnt_d;
            txBitIdx_q <= txBitIdx_d;
            txShift_q  <= txShift_d;
            txOut_q    <= txOut_d;
        end
    end

    // Each state computes the level tx shows for the next bit period.
    // tx is therefore taken directly from a register.
    always_comb begin
        txState_d  = txState_q;
        txCnt_d    = txCnt_q;
        txBitIdx_d = txBitIdx_q;
        txShift_d  = txShift_q;
        txOut_d    = txOut_q;
        txTake     = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                txOut_d = 1'b1;
                if (bufFull_q) begin
                    txTake    = 1'b1;
                    txShift_d = bufData_q;
                    txCnt_d   = '0;
                    txOut_d   = 1'b0;
                    txState_d = TX_START;
                end
            end
            TX_START: begin
                if (txCnt_q == BIT_LAST) begin
                    txCnt_d    = '0;
                    txBitIdx_d = '0;
                    txOut_d    = txShift_q[0];
                    txState_d  = TX_DATA;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt_q == BIT_LAST) begin
                    txCnt_d = '0;
                    if (txBitIdx_q == 3'd7) begin
                        txOut_d   = 1'b1;
                        txState_d = TX_STOP;
                    end else begin
                        txBitIdx_d = txBitIdx_q + 3'd1;
                        txShift_d  = {1'b0, txShift_q[7:1]};
                        txOut_d    = txShift_q[1];
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt_q == BIT_LAST) begin
                    txCnt_d   = '0;
                    txState_d = TX_IDLE;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    assign tx = txOut_q;

endmodule

// File: tb/tb_uart_loopback.sv
// Bench for uart_loopback, run at a reduced bit rate (16 clocks per bit).
// A queue of expected echoes is checked against frames decoded from tx.
module tb_uart_loopback;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         stopCycle;
    } expEntry_t;

    expEntry_t expQ[$];

    uart_loopback #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Drives one complete frame, starting from a negedge.
    // The expectation is queued when the stop bit starts.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit expectEcho);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        if (expectEcho) expQ.push_back('{data: data, stopCycle: cycle});
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic countTxLow(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
    endtask

    task automatic waitDrain(input string tag);
        int budget;
        budget = 30 * FRAME;
        while (expQ.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, expQ.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic int lowRunLen(input logic [7:0] b);
        int tz;
        tz = 8;
        for (int i = 7; i >= 0; i--) if (b[i]) tz = i;
        return CPB * (1 + tz);
    endfunction

    // Decodes each tx frame at mid-bit positions and checks it against the oldest expectation.
    // A frame cut short by reset is dropped.
    initial begin : txMonitor
        logic       s [FRAME];
        logic [7:0] got;
        int         startCycle, lowLen, expLen, lat;
        bit         aborted;
        expEntry_t  e;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                startCycle = cycle;
                aborted    = 1'b0;
                s[0]       = tx;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    s[k] = tx;
                    if (!rst_n) aborted = 1'b1;
                end
                if (!aborted) begin
                    for (int i = 0; i < 8; i++) got[i] = s[(i + 1) * CPB + CPB / 2];
                    lowLen = FRAME;
                    for (int k = FRAME - 1; k >= 0; k--) if (s[k] == 1'b1) lowLen = k;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", int'(got), -1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("echoByte", int'(got), int'(e.data));
                        checkOutput("stopBit", int'(s[9 * CPB + CPB / 2]), 1);
                        expLen = lowRunLen(e.data);
                        checkOutput($sformatf("startRunLen(%0d vs %0d)", lowLen, expLen),
                                    int'(lowLen >= expLen - 1 && lowLen <= expLen + 1), 1);
                        // Back-to-back echoes fall one idle clock further behind per frame, hence the slack.
                        lat = startCycle - e.stopCycle;
                        checkOutput($sformatf("echoLatency(%0d)", lat),
                                    int'(lat >= CPB / 2 && lat <= CPB / 2 + 12), 1);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int         lows;
        logic [7:0] b;
        bit         good;
        int         gap;
        logic [7:0] burst [3];

        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'h55;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("txDuringReset", int'(tx), 1);
        rst_n = 1'b1;

        countTxLow(20 * CPB, lows);
        checkOutput("idleTxQuiet", lows, 0);

        applyStimulus(8'h41, 1'b1, 1'b1);
        waitDrain("drainSingle");

        for (int i = 0; i < 3; i++) applyStimulus(burst[i], 1'b1, 1'b1);
        waitDrain("drainBurst");

        rx = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        rx = 1'b1;
        countTxLow(2 * FRAME, lows);
        checkOutput("glitchTxQuiet", lows, 0);

        applyStimulus(8'hA5, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        waitDrain("drainAfterFramingError");

        applyStimulus(8'h41, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("txLowBeforeReset", int'(tx), 0);
        #2;
        rst_n = 1'b0;
        rx    = 1'b0;
        #1;
        checkOutput("txAsyncReset", int'(tx), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rx = 1'b1;
        countTxLow(FRAME, lows);
        checkOutput("noFrameAfterLowRelease", lows, 0);
        applyStimulus(8'h7E, 1'b1, 1'b1);
        waitDrain("drainAfterReset");

        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
            gap  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
            repeat (gap) @(negedge clk);
            applyStimulus(b, good, good);
            if (!good) repeat (CPB) @(negedge clk);
        end
        waitDrain("drainRandom");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
